// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// minterm-count helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StFinish = 2'd3
  } tt_state_e;

  // Number of input combinations swept for an n_in-input DUT.
  function automatic int unsigned minterm_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter with a zero flag; times how long each minterm is held.
module tt_settle_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [Width-1:0] CntOne = 1;

  logic [Width-1:0] cnt_d, cnt_q;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of an attached N_IN-input, 1-output
// combinational DUT, holds each for SETTLE cycles, samples the output and
// compares it with a latched expected truth table.
// Optional macro TT_CAPTURE_EN adds the 'observed' capture port.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_fail,
`ifdef TT_CAPTURE_EN
  output logic [2**N_IN-1:0]   observed,
`endif
  output logic                 first_fail_valid
);

  localparam int unsigned NumMin = minterm_count(N_IN);
  localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IdxOne     = 1;
  localparam logic [N_IN-1:0] IdxLast    = '1;
  localparam logic [N_IN:0]   CountOne   = 1;

  tt_state_e state_d, state_q;

  logic [NumMin-1:0] exp_d, exp_q;
  logic [N_IN-1:0]   idx_d, idx_q;
  logic [N_IN:0]     mc_d, mc_q;
  logic [N_IN-1:0]   ff_d, ff_q;
  logic              ffv_d, ffv_q;
  logic              pass_d, pass_q;
  logic              settle_load, settle_dec, settle_zero;
  logic              miss;
`ifdef TT_CAPTURE_EN
  logic [NumMin-1:0] obs_d, obs_q;
`endif

  tt_settle_counter #(
    .Width (CntW)
  ) u_settle (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (settle_load),
    .load_val_i (SettleLoad),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

  // Next-state logic: sweep sequencing, comparison and result accumulation.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    mc_d        = mc_q;
    ff_d        = ff_q;
    ffv_d       = ffv_q;
    pass_d      = pass_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    miss        = (dut_out != exp_q[idx_q]);
`ifdef TT_CAPTURE_EN
    obs_d       = obs_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          exp_d       = expected;
          idx_d       = '0;
          mc_d        = '0;
          ff_d        = '0;
          ffv_d       = 1'b0;
          pass_d      = 1'b0;
          settle_load = 1'b1;
          state_d     = StSettle;
`ifdef TT_CAPTURE_EN
          obs_d       = '0;
`endif
        end
      end
      StSettle: begin
        if (settle_zero) begin
          state_d = StSample;
        end else begin
          settle_dec = 1'b1;
        end
      end
      StSample: begin
`ifdef TT_CAPTURE_EN
        obs_d[idx_q] = dut_out;
`endif
        if (miss) begin
          mc_d = mc_q + CountOne;
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q == IdxLast) begin
          // Pass is resolved here so it is already valid during the done pulse.
          pass_d  = (mc_d == '0);
          state_d = StFinish;
        end else begin
          idx_d       = idx_q + IdxOne;
          settle_load = 1'b1;
          state_d     = StSettle;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      exp_q   <= '0;
      idx_q   <= '0;
      mc_q    <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
`ifdef TT_CAPTURE_EN
      obs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      mc_q    <= mc_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
`ifdef TT_CAPTURE_EN
      obs_q   <= obs_d;
`endif
    end
  end

  assign dut_in           = idx_q;
  assign busy             = (state_q == StSettle) || (state_q == StSample);
  assign done             = (state_q == StFinish);
  assign pass             = pass_q;
  assign mismatch_count   = mc_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;
`ifdef TT_CAPTURE_EN
  assign observed         = obs_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with N_IN=2/SETTLE=1 driving
// s = x | ~y, one with N_IN=3/SETTLE=3 driving AND3.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: N_IN=2, SETTLE=1
  logic       start_a = 1'b0;
  logic [3:0] exp_a   = '0;
  logic [1:0] dut_in_a;
  logic       dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] mc_a;
  logic [1:0] ff_a;
`ifdef TT_CAPTURE_EN
  logic [3:0] obs_a;
`endif
  assign dut_out_a = dut_in_a[1] | ~dut_in_a[0];

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .start            (start_a),
    .expected         (exp_a),
    .dut_in           (dut_in_a),
    .dut_out          (dut_out_a),
    .busy             (busy_a),
    .done             (done_a),
    .pass             (pass_a),
    .mismatch_count   (mc_a),
    .first_fail       (ff_a),
`ifdef TT_CAPTURE_EN
    .observed         (obs_a),
`endif
    .first_fail_valid (ffv_a)
  );

  // Instance B: N_IN=3, SETTLE=3
  logic       start_b = 1'b0;
  logic [7:0] exp_b   = '0;
  logic [2:0] dut_in_b;
  logic       dut_out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] mc_b;
  logic [2:0] ff_b;
`ifdef TT_CAPTURE_EN
  logic [7:0] obs_b;
`endif
  assign dut_out_b = &dut_in_b;

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .start            (start_b),
    .expected         (exp_b),
    .dut_in           (dut_in_b),
    .dut_out          (dut_out_b),
    .busy             (busy_b),
    .done             (done_b),
    .pass             (pass_b),
    .mismatch_count   (mc_b),
    .first_fail       (ff_b),
`ifdef TT_CAPTURE_EN
    .observed         (obs_b),
`endif
    .first_fail_valid (ffv_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Starts a sweep on instance sel (0=A, 1=B), checks busy and dut_in each
  // cycle, optionally re-pulses start (expected=0) at cycle poke_t, and
  // returns the cycle index of the done pulse (-1 if it never came).
  task automatic sweep(input bit sel, input logic [7:0] exp_v, input int poke_t,
                       output int done_t);
    int s;
    s = sel ? 3 : 1;
    done_t = -1;
    @(negedge clk);
    if (sel) begin exp_b = exp_v; start_b = 1'b1; end
    else begin exp_a = exp_v[3:0]; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int t = 1; t <= 60 && done_t < 0; t++) begin
      if (t == poke_t) begin
        if (sel) begin exp_b = '0; start_b = 1'b1; end
        else begin exp_a = '0; start_a = 1'b1; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (sel ? done_b : done_a) begin
        done_t = t;
      end else begin
        check("busy", sel ? busy_b : busy_a, 1);
        check("dut_in_step", sel ? dut_in_b : dut_in_a, (t - 1) / (s + 1));
        @(negedge clk);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  typedef struct {
    logic [3:0] exp;
    logic       pass;
    int         cnt;
    int         ff;
    logic       ffv;
  } vec_t;

  vec_t vecs[5];
  int   dt;

  initial begin
    vecs[0] = '{exp: 4'b1101, pass: 1'b1, cnt: 0, ff: 0, ffv: 1'b0};
    vecs[1] = '{exp: 4'b1111, pass: 1'b0, cnt: 1, ff: 1, ffv: 1'b1};
    vecs[2] = '{exp: 4'b0100, pass: 1'b0, cnt: 2, ff: 0, ffv: 1'b1};
    vecs[3] = '{exp: 4'b0010, pass: 1'b0, cnt: 4, ff: 0, ffv: 1'b1};
    vecs[4] = '{exp: 4'b0000, pass: 1'b0, cnt: 3, ff: 0, ffv: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_count", mc_a, 0);
    check("rst_dut_in", dut_in_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_ff", ff_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_a, 0);

    // Table-driven sweeps on instance A
    for (int i = 0; i < 5; i++) begin
      sweep(1'b0, {4'b0, vecs[i].exp}, 0, dt);
      check("done_time", dt, 9);
      check("pass", pass_a, vecs[i].pass);
      check("mismatch_count", mc_a, vecs[i].cnt);
      check("first_fail", ff_a, vecs[i].ff);
      check("first_fail_valid", ffv_a, vecs[i].ffv);
      check("busy_at_done", busy_a, 0);
`ifdef TT_CAPTURE_EN
      check("observed", obs_a, 4'b1101);
`endif
      if (i == 0) begin
        // start during the done cycle must be ignored
        start_a = 1'b1;
        exp_a   = 4'b0000;
        @(negedge clk);
        start_a = 1'b0;
        check("finish_start_busy", busy_a, 0);
        check("finish_start_pass", pass_a, 1);
      end else begin
        @(negedge clk);
      end
      check("done_one_cycle", done_a, 0);
      check("dut_in_hold", dut_in_a, 3);
      check("pass_held", pass_a, vecs[i].pass);
    end

    // Restart attempt while busy, expected changed to 0000
    sweep(1'b0, 8'h0d, 3, dt);
    check("poke_done_time", dt, 9);
    check("poke_pass", pass_a, 1);
    check("poke_count", mc_a, 0);
    check("poke_ffv", ffv_a, 0);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      check("poke_no_second_done", done_a, 0);
      check("poke_idle", busy_a, 0);
    end

    // Reset mid-sweep
    @(negedge clk);
    exp_a   = 4'b1101;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_pass", pass_a, 0);
    check("midrst_count", mc_a, 0);
    check("midrst_dut_in", dut_in_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("postrst_no_done", done_a, 0);
    end
    sweep(1'b0, 8'h0f, 0, dt);
    check("postrst_done_time", dt, 9);
    check("postrst_pass", pass_a, 0);
    check("postrst_count", mc_a, 1);
    check("postrst_ff", ff_a, 1);
    check("postrst_ffv", ffv_a, 1);

    // Instance B: AND3, SETTLE=3
    sweep(1'b1, 8'b1000_0000, 0, dt);
    check("b_done_time", dt, 33);
    check("b_pass", pass_b, 1);
    check("b_count", mc_b, 0);
    check("b_ffv", ffv_b, 0);
`ifdef TT_CAPTURE_EN
    check("b_observed", obs_b, 8'b1000_0000);
`endif
    @(negedge clk);
    check("b_dut_in_hold", dut_in_b, 7);
    sweep(1'b1, 8'b1111_1111, 0, dt);
    check("b2_done_time", dt, 33);
    check("b2_pass", pass_b, 0);
    check("b2_count", mc_b, 7);
    check("b2_ff", ff_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
